// File: rtl/fetch_seq_ctrl.sv
// Multi-cycle fetch/issue sequencer: owns the PC, fetches over a valid/ready imem channel,
// issues to the IDU and waits for the EXU's next PC. Optional WAIT timeout: FETCH_TIMEOUT_EN.
module fetch_seq_ctrl #(
  parameter int unsigned XLEN           = 64,
  parameter logic [63:0] RESET_PC       = 64'h8000_0000,
  parameter int unsigned CNT_W          = 64,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [XLEN-1:0]  imem_req_addr,
  input  logic             imem_resp_valid,
  input  logic [31:0]      imem_resp_data,
  input  logic             imem_resp_err,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst,
  output logic [XLEN-1:0]  pc,
  input  logic             nextpc_valid,
  input  logic [XLEN-1:0]  nextpc,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_ISSUE, S_EXEC, S_HALT, S_FAULT
  } state_t;

  state_t           state, state_nx;
  logic [XLEN-1:0]  pc_q;
  logic [31:0]      inst_q;
  logic [CNT_W-1:0] cnt_q;
  logic             halted_q, fault_q;
  logic             latch_inst, take_npc, retire;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  logic [TO_W-1:0] to_cnt;
  logic            to_expire;

  // Counts WAIT cycles without a response; held at zero in every other state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state != S_WAIT) begin
      to_cnt <= '0;
    end else if (!imem_resp_valid) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign to_expire = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    latch_inst = 1'b0;
    take_npc   = 1'b0;
    retire     = 1'b0;
    case (state)
      S_IDLE:  state_nx = S_REQ;
      S_REQ:   if (imem_req_ready) state_nx = S_WAIT;
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (imem_resp_err) begin
            state_nx = S_FAULT;
          end else begin
            latch_inst = 1'b1;
            state_nx   = S_ISSUE;
          end
        end
`ifdef FETCH_TIMEOUT_EN
        else if (to_expire) begin
          state_nx = S_FAULT;
        end
`endif
      end
      S_ISSUE: begin
        if (inst_ready) begin
          if (inst_q == EBREAK) begin
            retire   = 1'b1;
            state_nx = S_HALT;
          end else begin
            state_nx = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        if (nextpc_valid) begin
          if (nextpc[1:0] != 2'b00) begin
            state_nx = S_FAULT;
          end else begin
            take_npc = 1'b1;
            retire   = 1'b1;
            state_nx = S_REQ;
          end
        end
      end
      S_HALT:  state_nx = S_HALT;
      S_FAULT: state_nx = S_FAULT;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= XLEN'(RESET_PC);
      inst_q   <= '0;
      cnt_q    <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      if (take_npc)   pc_q   <= nextpc;
      if (latch_inst) inst_q <= imem_resp_data;
      if (retire)     cnt_q  <= cnt_q + 1'b1;
      halted_q <= (state_nx == S_HALT);
      fault_q  <= (state_nx == S_FAULT);
    end
  end

  assign imem_req_valid = (state == S_REQ);
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state == S_ISSUE);
  assign inst           = inst_q;
  assign pc             = pc_q;
  assign halted         = halted_q;
  assign fault          = fault_q;
  assign retired_cnt    = cnt_q;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Self-checking bench for fetch_seq_ctrl: randomized memory/IDU/EXU timing against a
// transaction-level model of the PC and retired count.
module tb_fetch_seq_ctrl;

  localparam logic [63:0] RST_PC = 64'h8000_0000;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0, imem_resp_err = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] inst;
  logic [63:0] pc;
  logic        nextpc_valid = 1'b0;
  logic [63:0] nextpc = '0;
  logic        halted, fault;
  logic [63:0] retired_cnt;

  always #5 clk = ~clk;

  fetch_seq_ctrl #(
    .XLEN(64), .RESET_PC(RST_PC), .CNT_W(64), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .imem_resp_err(imem_resp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .pc(pc),
    .nextpc_valid(nextpc_valid), .nextpc(nextpc),
    .halted(halted), .fault(fault), .retired_cnt(retired_cnt)
  );

  int unsigned n_vec = 0, n_err = 0;
  logic [63:0] m_pc, m_cnt;

  task automatic clear_inputs();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_err   = 1'b0;
    inst_ready      = 1'b0;
    nextpc_valid    = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    m_pc  = RST_PC;
    m_cnt = '0;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == EBREAK) w = w ^ 32'h1;
    return w;
  endfunction

  // One full fetch/issue/execute transaction with the given latencies; checks along the way.
  task automatic exec_one(input logic [31:0] word, input logic [63:0] npc,
                          input int unsigned req_stall, input int unsigned resp_lat,
                          input int unsigned iss_stall, input int unsigned exe_lat);
    int unsigned t;
    t = 0;
    while (!imem_req_valid && t < 10) begin
      @(negedge clk);
      t++;
    end
    n_vec++;
    if (imem_req_valid !== 1'b1) begin
      n_err++; $display("FAIL req_wait: imem_req_valid=%b required 1", imem_req_valid);
    end
    for (int i = 0; i < int'(req_stall); i++) begin
      imem_req_ready  = 1'b0;
      imem_resp_valid = $urandom_range(0, 1);
      imem_resp_data  = $urandom;
      n_vec++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== m_pc || inst_valid !== 1'b0) begin
        n_err++;
        $display("FAIL req_hold: valid=%b addr=%h required valid=1 addr=%h", imem_req_valid, imem_req_addr, m_pc);
      end
      @(negedge clk);
    end
    imem_resp_valid = 1'b0;
    imem_req_ready  = 1'b1;
    n_vec++;
    if (imem_req_addr !== m_pc) begin
      n_err++; $display("FAIL req_addr: addr=%h required %h", imem_req_addr, m_pc);
    end
    @(negedge clk);
    imem_req_ready = 1'b0;
    for (int i = 0; i < int'(resp_lat); i++) begin
      inst_ready     = $urandom_range(0, 1);
      nextpc_valid   = $urandom_range(0, 1);
      nextpc         = {$urandom, $urandom} | 64'h2;
      imem_resp_data = $urandom;
      n_vec++;
      if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
        n_err++; $display("FAIL wait_quiet: req_valid=%b inst_valid=%b required 0/0", imem_req_valid, inst_valid);
      end
      @(negedge clk);
    end
    inst_ready      = 1'b0;
    nextpc_valid    = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_err   = 1'b0;
    imem_resp_data  = word;
    n_vec++;
    if (imem_req_valid !== 1'b0) begin
      n_err++; $display("FAIL single_req: imem_req_valid=%b required 0", imem_req_valid);
    end
    @(negedge clk);
    imem_resp_valid = 1'b0;
    for (int i = 0; i < int'(iss_stall); i++) begin
      inst_ready      = 1'b0;
      imem_resp_valid = $urandom_range(0, 1);
      imem_resp_data  = $urandom;
      nextpc_valid    = $urandom_range(0, 1);
      nextpc          = {$urandom, $urandom} | 64'h1;
      n_vec++;
      if (inst_valid !== 1'b1 || inst !== word || pc !== m_pc) begin
        n_err++;
        $display("FAIL issue_hold: valid=%b inst=%h pc=%h required 1 %h %h", inst_valid, inst, pc, word, m_pc);
      end
      @(negedge clk);
    end
    imem_resp_valid = 1'b0;
    nextpc_valid    = 1'b0;
    inst_ready      = 1'b1;
    n_vec++;
    if (inst_valid !== 1'b1 || inst !== word || pc !== m_pc) begin
      n_err++;
      $display("FAIL issue: valid=%b inst=%h pc=%h required 1 %h %h", inst_valid, inst, pc, word, m_pc);
    end
    @(negedge clk);
    inst_ready = 1'b0;
    if (word == EBREAK) begin
      m_cnt = m_cnt + 1;
      n_vec++;
      if (halted !== 1'b1 || retired_cnt !== m_cnt || inst_valid !== 1'b0) begin
        n_err++;
        $display("FAIL halt_entry: halted=%b cnt=%0d required 1 %0d", halted, retired_cnt, m_cnt);
      end
      return;
    end
    n_vec++;
    if (inst_valid !== 1'b0) begin
      n_err++; $display("FAIL single_issue: inst_valid=%b required 0", inst_valid);
    end
    for (int i = 0; i < int'(exe_lat); i++) begin
      inst_ready      = $urandom_range(0, 1);
      imem_resp_valid = $urandom_range(0, 1);
      imem_resp_err   = 1'b1;
      n_vec++;
      if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || fault !== 1'b0) begin
        n_err++;
        $display("FAIL exec_quiet: req=%b iv=%b fault=%b required 0 0 0", imem_req_valid, inst_valid, fault);
      end
      @(negedge clk);
    end
    inst_ready      = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_err   = 1'b0;
    nextpc_valid    = 1'b1;
    nextpc          = npc;
    @(negedge clk);
    nextpc_valid = 1'b0;
    if (npc[1:0] != 2'b00) begin
      n_vec++;
      if (fault !== 1'b1 || pc !== m_pc || retired_cnt !== m_cnt) begin
        n_err++;
        $display("FAIL misalign: fault=%b pc=%h cnt=%0d required 1 %h %0d", fault, pc, retired_cnt, m_pc, m_cnt);
      end
    end else begin
      m_pc  = npc;
      m_cnt = m_cnt + 1;
      n_vec++;
      if (pc !== m_pc || retired_cnt !== m_cnt || imem_req_valid !== 1'b1 || imem_req_addr !== m_pc) begin
        n_err++;
        $display("FAIL retire: pc=%h cnt=%0d req=%b required %h %0d 1", pc, retired_cnt, imem_req_valid, m_pc, m_cnt);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    #1;
    n_vec++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || halted !== 1'b0 || fault !== 1'b0 ||
        pc !== RST_PC || inst !== 32'h0 || retired_cnt !== 64'h0) begin
      n_err++;
      $display("FAIL reset_state: rv=%b iv=%b h=%b f=%b pc=%h inst=%h cnt=%0d required 0 0 0 0 %h 0 0",
               imem_req_valid, inst_valid, halted, fault, pc, inst, retired_cnt, RST_PC);
    end
    @(negedge clk);
    rst = 1'b0;
    m_pc  = RST_PC;
    m_cnt = '0;
    n_vec++;
    if (imem_req_valid !== 1'b0) begin
      n_err++; $display("FAIL idle_cycle: imem_req_valid=%b required 0", imem_req_valid);
    end
    @(negedge clk);
    n_vec++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
      n_err++;
      $display("FAIL first_req: valid=%b addr=%h required 1 %h", imem_req_valid, imem_req_addr, RST_PC);
    end
  endtask

  task automatic test_basic();
    exec_one(32'h0000_0013, 64'h8000_0004, 0, 0, 0, 0);
    n_vec++;
    if (imem_req_addr !== 64'h8000_0004 || retired_cnt !== 64'd1) begin
      n_err++;
      $display("FAIL basic: addr=%h cnt=%0d required 8000_0004 1", imem_req_addr, retired_cnt);
    end
  endtask

  task automatic test_stream_halt();
    apply_reset();
    for (int k = 0; k < 3; k++)
      exec_one(rand_word(), m_pc + 64'(4 * $urandom_range(1, 8)),
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    exec_one(EBREAK, 64'h0, 1, 1, 1, 0);
    for (int i = 0; i < 20; i++) begin
      imem_req_ready  = 1'b1;
      imem_resp_valid = $urandom_range(0, 1);
      inst_ready      = 1'b1;
      nextpc_valid    = 1'b1;
      nextpc          = 64'h8000_1000;
      @(negedge clk);
      n_vec++;
      if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || halted !== 1'b1 ||
          retired_cnt !== 64'd4 || pc !== m_pc || fault !== 1'b0) begin
        n_err++;
        $display("FAIL halt_hold: req=%b iv=%b h=%b cnt=%0d pc=%h required 0 0 1 4 %h",
                 imem_req_valid, inst_valid, halted, retired_cnt, pc, m_pc);
      end
    end
    clear_inputs();
  endtask

  task automatic test_stall();
    apply_reset();
    exec_one(rand_word(), 64'h8000_0010, 5, 1, 3, 2);
  endtask

  task automatic test_resp_err();
    apply_reset();
    exec_one(rand_word(), 64'h8000_0040, 0, 0, 0, 0);
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_err   = 1'b1;
    @(negedge clk);
    clear_inputs();
    n_vec++;
    if (fault !== 1'b1 || pc !== 64'h8000_0040 || inst_valid !== 1'b0) begin
      n_err++; $display("FAIL resp_err: fault=%b pc=%h required 1 8000_0040", fault, pc);
    end
    imem_req_ready = 1'b1;
    repeat (5) @(negedge clk);
    n_vec++;
    if (imem_req_valid !== 1'b0 || fault !== 1'b1 || pc !== 64'h8000_0040) begin
      n_err++; $display("FAIL fault_hold: req=%b fault=%b pc=%h required 0 1 8000_0040", imem_req_valid, fault, pc);
    end
    clear_inputs();
  endtask

  task automatic test_misaligned();
    apply_reset();
    exec_one(rand_word(), 64'h8000_0006, 0, 0, 0, 1);
    repeat (3) @(negedge clk);
    n_vec++;
    if (imem_req_valid !== 1'b0 || halted !== 1'b0 || pc !== RST_PC) begin
      n_err++; $display("FAIL misalign_hold: req=%b halted=%b pc=%h required 0 0 %h", imem_req_valid, halted, pc, RST_PC);
    end
  endtask

  task automatic test_reset_mid_wait();
    apply_reset();
    exec_one(rand_word(), 64'h8000_0100, 0, 0, 0, 0);
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    n_vec++;
    if (retired_cnt !== 64'h0 || pc !== RST_PC || imem_req_valid !== 1'b0) begin
      n_err++; $display("FAIL mid_reset: cnt=%0d pc=%h required 0 %h", retired_cnt, pc, RST_PC);
    end
    @(negedge clk);
    rst = 1'b0;
    m_pc  = RST_PC;
    m_cnt = '0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++;
      if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC || retired_cnt !== 64'h0) begin
        n_err++;
        $display("FAIL stale_resp: iv=%b req=%b addr=%h cnt=%0d required 0 1 %h 0",
                 inst_valid, imem_req_valid, imem_req_addr, retired_cnt, RST_PC);
      end
    end
    imem_resp_valid = 1'b0;
    exec_one(rand_word(), 64'h8000_0008, 0, 1, 0, 0);
  endtask

  task automatic test_timeout();
    apply_reset();
    exec_one(rand_word(), 64'h8000_0200, 0, 0, 0, 0);
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < int'(TO); i++) begin
      n_vec++;
      if (fault !== 1'b0) begin
        n_err++; $display("FAIL timeout_early: wait cycle %0d fault=%b required 0", i + 1, fault);
      end
      @(negedge clk);
    end
    n_vec++;
    if (fault !== 1'b1 || pc !== 64'h8000_0200) begin
      n_err++; $display("FAIL timeout: fault=%b pc=%h required 1 8000_0200", fault, pc);
    end
`else
    repeat (100) @(negedge clk);
    n_vec++;
    if (fault !== 1'b0 || inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      n_err++; $display("FAIL no_timeout: fault=%b iv=%b req=%b required 0 0 0", fault, inst_valid, imem_req_valid);
    end
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h1234_5673;
    @(negedge clk);
    imem_resp_valid = 1'b0;
    n_vec++;
    if (inst_valid !== 1'b1 || inst !== 32'h1234_5673) begin
      n_err++; $display("FAIL late_resp: iv=%b inst=%h required 1 12345673", inst_valid, inst);
    end
`endif
  endtask

  task automatic test_random();
    apply_reset();
    for (int k = 0; k < 30; k++)
      exec_one(rand_word(), {$urandom, $urandom} & ~64'h3,
               $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
    exec_one(EBREAK, 64'h0, 0, 0, 0, 0);
    n_vec++;
    if (retired_cnt !== 64'd31) begin
      n_err++; $display("FAIL random_total: cnt=%0d required 31", retired_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stream_halt();
    test_stall();
    test_resp_err();
    test_misaligned();
    test_reset_mid_wait();
    test_timeout();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
